// File: rtl/multi_sonar_ctrl_pkg.sv
// Shared definitions for the multi-channel ultrasonic sonar controller:
// 4-bit FSM state codes and default timing constants (50 MHz clock).
package multi_sonar_ctrl_pkg;

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    DISPARO     = 4'd1,
    ESPERA_ECHO = 4'd2,
    MEDINDO     = 4'd3,
    ARMAZENA    = 4'd4,
    PROXIMO     = 4'd5,
    FIM         = 4'd6,
    INTERVALO   = 4'd7
  } estado_t;

  localparam int DEF_N_CH           = 3;
  localparam int DEF_DIST_W         = 12;
  localparam int DEF_TRIG_CYCLES    = 500;
  localparam int DEF_DIV_CM         = 2941;
  localparam int DEF_TIMEOUT_CYCLES = 1_500_000;
  localparam int DEF_GAP_CYCLES     = 3_000_000;

endpackage

// File: rtl/multi_sonar_ctrl_echo_meter.sv
// Shared echo meter: clocks-per-cm prescaler, saturating cm counter and a
// timeout counter; the controller muxes the active channel onto it.
module echo_meter
  import multi_sonar_ctrl_pkg::*;
#(
  parameter int DIST_W         = DEF_DIST_W,
  parameter int DIV_CM         = DEF_DIV_CM,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_clr,
  input  logic              i_cnt_en,
  input  logic              i_meas_en,
  output logic [DIST_W-1:0] o_dist,
  output logic              o_tmo
);

  localparam int PW = (DIV_CM > 1) ? $clog2(DIV_CM) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV_CM - 1);
  localparam logic [TW-1:0]     TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DIST_W-1:0] CM_MAX     = '1;

  logic [PW-1:0]     r_presc;
  logic [TW-1:0]     r_tmo_cnt;
  logic [DIST_W-1:0] r_cm;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_presc   <= '0;
      r_tmo_cnt <= '0;
      r_cm      <= '0;
    end else if (i_clr) begin
      r_presc   <= '0;
      r_tmo_cnt <= '0;
      r_cm      <= '0;
    end else begin
      // The timeout counter parks at its last value so it can never wrap.
      if (i_cnt_en && (r_tmo_cnt != TMO_LAST))
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      if (i_meas_en) begin
        if (r_presc == PRESC_LAST) begin
          r_presc <= '0;
          if (r_cm != CM_MAX)
            r_cm <= r_cm + DIST_W'(1);
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  assign o_dist = r_cm;
  assign o_tmo  = (r_tmo_cnt == TMO_LAST);

endmodule

// File: rtl/multi_sonar_ctrl.sv
// Sequences N_CH ultrasonic sensors one at a time: trigger, wait for echo,
// time the echo pulse and store the distance, in single or continuous sweeps.
module multi_sonar_ctrl
  import multi_sonar_ctrl_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int DIST_W         = DEF_DIST_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int DIV_CM         = DEF_DIV_CM,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ligar,
  input  logic                     modo,
  input  logic                     parar,
  input  logic [N_CH-1:0]          echo,
  output logic [N_CH-1:0]          trigger,
  output logic [N_CH*DIST_W-1:0]   distancia,
  output logic [N_CH-1:0]          timeout,
  output logic [N_CH-1:0]          valido,
  output logic                     pronto,
  output logic                     ocupado,
  output logic [3:0]               db_estado
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CMAX  = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_CH - 1);
  localparam logic [CW-1:0]    TRIG_LAST = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0]    GAP_LAST  = CW'(GAP_CYCLES - 1);

  estado_t           r_estado, w_proximo;
  logic [IDX_W-1:0]  r_idx;
  logic [CW-1:0]     r_cnt;
  logic              r_modo, r_parar, r_tmo;
  logic [N_CH-1:0]   r_sync1, r_sync2, r_echo_d;
  logic [DIST_W-1:0] r_dist [N_CH];
  logic [N_CH-1:0]   r_timeout, r_valido;
  logic              w_rise, w_high, w_stop;
  logic              w_clr, w_cnt_en, w_meas_en, w_tmo, w_tmo_evt;
  logic [DIST_W-1:0] w_dist;

  // A rise needs a low sample behind it, so an echo already high is ignored.
  assign w_rise = r_sync2[r_idx] & ~r_echo_d[r_idx];
  assign w_high = r_echo_d[r_idx];
  assign w_stop = r_parar | parar;

  echo_meter #(
    .DIST_W         (DIST_W),
    .DIV_CM         (DIV_CM),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_meter (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_clr     (w_clr),
    .i_cnt_en  (w_cnt_en),
    .i_meas_en (w_meas_en),
    .o_dist    (w_dist),
    .o_tmo     (w_tmo)
  );

  always_comb begin
    w_proximo = r_estado;
    w_clr     = 1'b0;
    w_cnt_en  = 1'b0;
    w_meas_en = 1'b0;
    w_tmo_evt = 1'b0;
    case (r_estado)
      OCIOSO:      if (ligar) w_proximo = DISPARO;
      DISPARO: begin
        w_clr = 1'b1;
        if (r_cnt == TRIG_LAST) w_proximo = ESPERA_ECHO;
      end
      ESPERA_ECHO: begin
        if (w_rise) begin
          w_clr     = 1'b1;
          w_proximo = MEDINDO;
        end else begin
          w_cnt_en  = 1'b1;
          w_tmo_evt = w_tmo;
          if (w_tmo) w_proximo = ARMAZENA;
        end
      end
      MEDINDO: begin
        w_cnt_en  = w_high;
        w_meas_en = w_high;
        w_tmo_evt = w_high & w_tmo;
        if (!w_high || w_tmo) w_proximo = ARMAZENA;
      end
      ARMAZENA:    w_proximo = PROXIMO;
      PROXIMO:     w_proximo = (r_idx == IDX_LAST) ? FIM : DISPARO;
      FIM:         w_proximo = (r_modo && !w_stop) ? INTERVALO : OCIOSO;
      INTERVALO: begin
        if (w_stop)                w_proximo = OCIOSO;
        else if (r_cnt == GAP_LAST) w_proximo = DISPARO;
      end
      default:     w_proximo = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado  <= OCIOSO;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_modo    <= 1'b0;
      r_parar   <= 1'b0;
      r_tmo     <= 1'b0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_echo_d  <= '0;
      r_timeout <= '0;
      r_valido  <= '0;
      for (int k = 0; k < N_CH; k++) r_dist[k] <= '0;
    end else begin
      r_estado <= w_proximo;
      r_sync1  <= echo;
      r_sync2  <= r_sync1;
      r_echo_d <= r_sync2;
      r_parar  <= (r_estado == OCIOSO || w_proximo == OCIOSO) ? 1'b0 : (r_parar | parar);

      if (r_estado == OCIOSO && ligar) begin
        r_idx  <= '0;
        r_modo <= modo;
      end else if (r_estado == PROXIMO && r_idx != IDX_LAST) begin
        r_idx <= r_idx + IDX_W'(1);
      end else if (r_estado == INTERVALO && w_proximo == DISPARO) begin
        r_idx <= '0;
      end

      if (w_proximo != r_estado)
        r_cnt <= '0;
      else if (r_estado == DISPARO || r_estado == INTERVALO)
        r_cnt <= r_cnt + CW'(1);

      if (w_proximo == ARMAZENA)
        r_tmo <= w_tmo_evt;

      if (r_estado == ARMAZENA) begin
        for (int k = 0; k < N_CH; k++) begin
          if (IDX_W'(k) == r_idx) begin
            r_dist[k]    <= r_tmo ? '1 : w_dist;
            r_timeout[k] <= r_tmo;
            r_valido[k]  <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    trigger = '0;
    if (r_estado == DISPARO) trigger[r_idx] = 1'b1;
    for (int k = 0; k < N_CH; k++) distancia[k*DIST_W +: DIST_W] = r_dist[k];
  end

  assign timeout   = r_timeout;
  assign valido    = r_valido;
  assign pronto    = (r_estado == FIM);
  assign ocupado   = (r_estado != OCIOSO);
  assign db_estado = r_estado;

endmodule

// File: doc/multi_sonar_ctrl.md
MULTI_SONAR_CTRL -- requirements
Module: multi_sonar_ctrl

Interface
REQ-001 Parameter N_CH, default 3: number of ultrasonic channels; legal range 1..8.
REQ-002 Parameter DIST_W, default 12: width of each distance result in cm.
REQ-003 Parameter TRIG_CYCLES, default 500: trigger pulse width in clocks (10 us at 50 MHz).
REQ-004 Parameter DIV_CM, default 2941: echo-high clocks per cm.
REQ-005 Parameter TIMEOUT_CYCLES, default 1_500_000: maximum wait for echo rise, and maximum echo-high duration.
REQ-006 Parameter GAP_CYCLES, default 3_000_000: idle gap between sweeps in continuous mode.
REQ-007 Port clock, input, 1: single system clock; all logic on its rising edge.
REQ-008 Port reset, input, 1: asynchronous, active-high reset.
REQ-009 Port ligar, input, 1: start request, one-cycle pulse already edge-detected upstream.
REQ-010 Port modo, input, 1: 0 = single sweep, 1 = continuous sweeps.
REQ-011 Port parar, input, 1: ends continuous mode after the current sweep.
REQ-012 Port echo, input, N_CH: asynchronous echo lines, one per channel.
REQ-013 Port trigger, output, N_CH: trigger pulses, one-hot or zero.
REQ-014 Port distancia, output, N_CH*DIST_W: channel k occupies bits [k*DIST_W +: DIST_W].
REQ-015 Port timeout, output, N_CH: per-channel flag, set when the last measurement on that channel timed out.
REQ-016 Port valido, output, N_CH: per-channel flag, set when the channel has held a result since reset.
REQ-017 Port pronto, output, 1: one-cycle pulse at the end of each full sweep.
REQ-018 Port ocupado, output, 1: high whenever the FSM is not in OCIOSO.
REQ-019 Port db_estado, output, 4: current FSM state code.

Function
REQ-020 Each echo bit SHALL pass through a 2-flop synchronizer before use; the 2-cycle latency is part of the specified timing.
REQ-021 FSM states SHALL be OCIOSO, DISPARO, ESPERA_ECHO, MEDINDO, ARMAZENA, PROXIMO, FIM and INTERVALO.
REQ-022 OCIOSO -> DISPARO on ligar; the channel index SHALL clear to 0 and modo SHALL be sampled into an internal register.
REQ-023 ligar SHALL be ignored outside OCIOSO.
REQ-024 DISPARO: trigger[idx] SHALL be high for exactly TRIG_CYCLES clocks, then the FSM enters ESPERA_ECHO.
REQ-025 ESPERA_ECHO: on synchronized echo[idx] rise -> MEDINDO; after TIMEOUT_CYCLES clocks with no rise -> ARMAZENA with the timeout condition.
REQ-026 MEDINDO: count clocks while echo is high using a DIV_CM prescaler plus a cm counter.
REQ-027 MEDINDO: on echo fall -> ARMAZENA; if echo stays high for TIMEOUT_CYCLES clocks -> ARMAZENA with the timeout condition.
REQ-028 Distance SHALL be floor(high_clocks / DIV_CM), saturating at 2^DIST_W-1 with no wrap-around.
REQ-029 ARMAZENA (1 cycle): write distancia[idx] and set valido[idx].
REQ-030 ARMAZENA: on timeout, write all-ones to distancia[idx] and set timeout[idx]; otherwise clear timeout[idx].
REQ-031 PROXIMO: if idx < N_CH-1, increment idx -> DISPARO; else -> FIM.
REQ-032 FIM (1 cycle): pronto=1.
REQ-033 FIM: if the sampled modo is 1 and parar has not been seen since start -> INTERVALO; else -> OCIOSO.
REQ-034 INTERVALO: wait GAP_CYCLES, then idx=0 -> DISPARO.
REQ-035 parar asserted in any state SHALL be latched; it SHALL abort INTERVALO immediately -> OCIOSO.
REQ-036 A parar that is latched before FIM SHALL cause FIM -> OCIOSO instead of INTERVALO.
REQ-037 The parar latch SHALL clear on entry to OCIOSO.
REQ-038 Result registers SHALL hold their value until overwritten by the same channel; other channels SHALL be unaffected.
REQ-039 An echo already high at DISPARO entry SHALL NOT be measured; ESPERA_ECHO requires a low->high transition.

Reset
REQ-040 Reset SHALL be asynchronous and active-high; on assertion the FSM goes to OCIOSO immediately, including mid-measurement.
REQ-041 On reset, trigger=0, distancia=0, timeout=0, valido=0, pronto=0, ocupado=0, all counters 0, and the parar latch cleared.
REQ-042 The synchronizer flops SHALL reset to 0.

Structure
REQ-043 State encodings (4-bit) and default timing constants SHALL live in a shared header/package used by the top-level and the bench.
REQ-044 One sub-module, echo_meter, SHALL contain the prescaler, the cm counter with saturation, and the timeout counter, shared across channels through the idx mux.

Verification (bench parameters: N_CH=3, DIST_W=8, TRIG_CYCLES=5, DIV_CM=10, TIMEOUT_CYCLES=300, GAP_CYCLES=50)
REQ-045 Single sweep: ligar, echo highs of 123/57/9 clocks -> distancia 12/5/0, valido=111, timeout=000, exactly one pronto, then OCIOSO.
REQ-046 Timeout: channel 1 echo never rises -> distancia[1]=255, timeout=010, channels 0/2 correct, pronto still occurs.
REQ-047 Saturation: echo high for 290 clocks with DIST_W=4 -> distance 15, not 13; no timeout.
REQ-048 Continuous mode: modo=1, two sweeps with a 50-cycle gap, parar during sweep 2 -> two pronto pulses, then OCIOSO.
REQ-049 Reset mid-MEDINDO: assert reset -> all outputs 0 the same cycle; after release, ligar restarts cleanly from channel 0.
REQ-050 Busy ignore: ligar pulsed during DISPARO of channel 1 -> no restart, idx unchanged, one pronto per sweep.
